// File: rtl/piso7_pkg.sv
// ============================================================
// Module  : piso7_pkg
// Brief   : Shared types and constants for the 7-bit PISO sequencer.
// Revision: 1.0
// ============================================================
`default_nettype none

package piso7_pkg;

  localparam int WORD_W = 7;
  localparam int SEL_W  = 3;
  localparam logic [SEL_W-1:0] LAST_SEL = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/piso7_sequencer_mux.sv
// ============================================================
// Module  : MUX7_1
// Brief   : 7:1 bit selector; an out-of-range select yields 0.
// Revision: 1.0
// ============================================================
`default_nettype none

module MUX7_1
  import piso7_pkg::*;
(
  input  logic [0:WORD_W-1] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      3'd0:    y = data[0];
      3'd1:    y = data[1];
      3'd2:    y = data[2];
      3'd3:    y = data[3];
      3'd4:    y = data[4];
      3'd5:    y = data[5];
      3'd6:    y = data[6];
      default: y = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/piso7_sequencer.sv
// ============================================================
// Module  : piso7_sequencer
// Brief   : Loads a 7-bit word over valid/ready and serialises it
//           bit 0 first through MUX7_1, with first/last framing.
// Revision: 1.0
// ============================================================
`default_nettype none

module piso7_sequencer
  import piso7_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:WORD_W-1] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_first,
  output logic              ser_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [0:WORD_W-1]   r_data;
  logic                w_last;
  logic                w_load;
  logic                w_beat;
  logic                w_gap_done;

  assign w_last    = (r_sel == LAST_SEL);
  assign ser_valid = (r_state == ST_SHIFT);
  // Zero-bubble streaming: the final beat of a word doubles as a load slot.
  assign in_ready  = (r_state == ST_IDLE) ||
                     ((GAP == 0) && ser_valid && w_last && ser_ready);
  assign w_load    = in_valid && in_ready;
  assign w_beat    = ser_valid && ser_ready;
  assign ser_first = ser_valid && (r_sel == '0);
  assign ser_last  = ser_valid && w_last;
  assign busy      = (r_state != ST_IDLE);
  assign sel       = r_sel;

  generate
    if (GAP > 0) begin : g_gap
      localparam logic [3:0] c_gap_init = 4'(GAP - 1);
      logic [3:0] r_gap;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_gap <= 4'd0;
        end else if (w_beat && w_last) begin
          r_gap <= c_gap_init;
        end else if ((r_state == ST_GAP) && (r_gap != 4'd0)) begin
          r_gap <= r_gap - 4'd1;
        end
      end

      assign w_gap_done = (r_gap == 4'd0);
    end else begin : g_no_gap
      assign w_gap_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_data  <= in_data;
            r_sel   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_beat) begin
            if (!w_last) begin
              r_sel <= r_sel + 3'd1;
            end else begin
              r_sel <= '0;
              if (GAP != 0) begin
                r_state <= ST_GAP;
              end else if (w_load) begin
                r_data <= in_data;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  MUX7_1 u_mux (
    .data (r_data),
    .sel  (r_sel),
    .y    (ser_out)
  );

endmodule

`default_nettype wire
